// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and optional hold timeout.
// Winner is registered as id+valid and decoded to a one-hot grant from registers only.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit HOLD_EN = (MAX_HOLD != 0);

    logic [0:0]       state, state_d;
    logic [1:0]       ptr, ptr_d;
    logic [CNT_W-1:0] hold_cnt, hold_d;
    logic [1:0]       id_d;
    logic             valid_d;
    logic             to_d;
    logic             win_found;
    logic [1:0]       win_id;
    logic [1:0]       idx;
    logic             owner_req;
    logic             expire;

    // Rotating priority scan; walking from the far end leaves the nearest request as winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        idx       = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        hold_d    = hold_cnt;
        id_d      = gnt_id;
        valid_d   = gnt_valid;
        to_d      = 1'b0;
        owner_req = req[gnt_id];
        expire    = HOLD_EN && (hold_cnt == HOLD_LAST);
        case (state)
            STATE_IDLE: begin
                if (win_found) begin
                    state_d = STATE_BUSY;
                    id_d    = win_id;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            STATE_BUSY: begin
                // A release always passes through IDLE so the bus sees a turnaround cycle.
                if (!owner_req || expire) begin
                    state_d = STATE_IDLE;
                    valid_d = 1'b0;
                    ptr_d   = gnt_id + 2'd1;
                    hold_d  = '0;
                    to_d    = owner_req;
                end else if (hold_cnt != CNT_MAX) begin
                    hold_d = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = STATE_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STATE_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_d;
            gnt_id    <= id_d;
            gnt_valid <= valid_d;
            timeout   <= to_d;
        end
    end

    // One-hot decode of the registered owner; no path from req.
    always_comb begin
        gnt = '0;
        for (int k = 0; k < 4; k++) begin
            gnt[k] = gnt_valid && (gnt_id == 2'(k));
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed vector table, hand sequences and a random run
// against an owner/pointer reference model, on MAX_HOLD = 8, 4 and 0 instances.
module tb_rr_arbiter4;

    logic       clk;
    logic       reset_n;
    logic [3:0] req8, req4, req0;
    logic [3:0] gnt8, gnt4, gnt0;
    logic [1:0] id8, id4, id0;
    logic       v8, v4, v0;
    logic       to8, to4, to0;

    int total = 0;
    int bad   = 0;

    rr_arbiter4 #(.MAX_HOLD(8)) u8 (.clk(clk), .reset_n(reset_n), .req(req8), .gnt(gnt8),
                                    .gnt_id(id8), .gnt_valid(v8), .timeout(to8));
    rr_arbiter4 #(.MAX_HOLD(4)) u4 (.clk(clk), .reset_n(reset_n), .req(req4), .gnt(gnt4),
                                    .gnt_id(id4), .gnt_valid(v4), .timeout(to4));
    rr_arbiter4 #(.MAX_HOLD(0)) u0 (.clk(clk), .reset_n(reset_n), .req(req0), .gnt(gnt0),
                                    .gnt_id(id0), .gnt_valid(v0), .timeout(to0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         id;
        bit         v;
        bit         to;
    } vec_t;

    // owner = -1 when nobody holds the resource; held counts grant cycles so far
    typedef struct {
        int owner;
        int ptr;
        int held;
        int last_id;
        bit to;
    } mdl_t;

    vec_t tbl[$];
    mdl_t m8, m4, m0;

    function automatic vec_t mk(logic [3:0] r, int id, bit v, bit to);
        vec_t x;
        x.req = r;
        x.id  = id;
        x.v   = v;
        x.to  = to;
        return x;
    endfunction

    function automatic logic [7:0] expv(bit v, int id, bit to);
        logic [3:0] g;
        g = v ? 4'(1 << id) : 4'b0000;
        return {to, v, 2'(id), g};
    endfunction

    function automatic mdl_t mreset();
        mdl_t n;
        n.owner   = -1;
        n.ptr     = 0;
        n.held    = 0;
        n.last_id = 0;
        n.to      = 1'b0;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [3:0] r, int mh);
        mdl_t n;
        int   c;
        n    = m;
        n.to = 1'b0;
        if (m.owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                c = (m.ptr + k) % 4;
                if (r[c] && n.owner < 0) begin
                    n.owner = c;
                    n.held  = 1;
                end
            end
        end else if (!r[m.owner] || (mh != 0 && m.held == mh)) begin
            n.to      = r[m.owner];
            n.ptr     = (m.owner + 1) % 4;
            n.last_id = m.owner;
            n.owner   = -1;
            n.held    = 0;
        end else begin
            n.held = m.held + 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] mexp(mdl_t m);
        return expv(m.owner >= 0, (m.owner >= 0) ? m.owner : m.last_id, m.to);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {to,v,id,gnt}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req8 = 4'b1111;
        req4 = 4'b0000;
        req0 = 4'b0000;

        // reset holds outputs low even with every request asserted
        tick();
        check("reset_a", {to8, v8, id8, gnt8}, 8'h00);
        tick();
        check("reset_b", {to8, v8, id8, gnt8}, 8'h00);
        reset_n = 1'b1;

        tbl.push_back(mk(4'b1111, 0, 1, 0));
        tbl.push_back(mk(4'b1111, 0, 1, 0));
        tbl.push_back(mk(4'b1110, 0, 0, 0));
        tbl.push_back(mk(4'b1111, 1, 1, 0));
        tbl.push_back(mk(4'b1111, 1, 1, 0));
        tbl.push_back(mk(4'b1101, 1, 0, 0));
        tbl.push_back(mk(4'b1111, 2, 1, 0));
        tbl.push_back(mk(4'b1111, 2, 1, 0));
        tbl.push_back(mk(4'b1011, 2, 0, 0));
        tbl.push_back(mk(4'b1111, 3, 1, 0));
        tbl.push_back(mk(4'b1111, 3, 1, 0));
        tbl.push_back(mk(4'b0111, 3, 0, 0));
        tbl.push_back(mk(4'b0100, 2, 1, 0));
        tbl.push_back(mk(4'b0100, 2, 1, 0));
        tbl.push_back(mk(4'b0000, 2, 0, 0));
        tbl.push_back(mk(4'b0011, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0));
        tbl.push_back(mk(4'b1000, 3, 1, 0));
        tbl.push_back(mk(4'b1001, 3, 1, 0));
        tbl.push_back(mk(4'b1001, 3, 1, 0));
        tbl.push_back(mk(4'b0001, 3, 0, 0));
        tbl.push_back(mk(4'b0001, 0, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0));

        foreach (tbl[i]) begin
            req8 = tbl[i].req;
            tick();
            check($sformatf("vec%0d", i), {to8, v8, id8, gnt8},
                  expv(tbl[i].v, tbl[i].id, tbl[i].to));
        end

        // asynchronous reset in the middle of a grant to ID 2
        req8 = 4'b0100;
        tick();
        check("pre_async", {to8, v8, id8, gnt8}, expv(1, 2, 0));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_drop", {to8, v8, id8, gnt8}, 8'h00);
        #1;
        reset_n = 1'b1;
        req8 = 4'b1111;
        tick();
        check("async_ptr0", {to8, v8, id8, gnt8}, expv(1, 0, 0));
        req8 = 4'b0000;
        tick();
        check("async_rel", {to8, v8, id8, gnt8}, expv(0, 0, 0));

        // hold timeout with a competing request
        req4 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_hold%0d", i), {to4, v4, id4, gnt4}, expv(1, 1, 0));
        end
        tick();
        check("to_pulse", {to4, v4, id4, gnt4}, expv(0, 1, 1));
        tick();
        check("to_next2", {to4, v4, id4, gnt4}, expv(1, 2, 0));
        req4 = 4'b0000;
        tick();
        check("to_rel", {to4, v4, id4, gnt4}, expv(0, 2, 0));

        // timeout disabled: grant persists well past counter saturation
        req0 = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            tick();
            check($sformatf("nohold%0d", i), {to0, v0, id0, gnt0}, expv(1, 0, 0));
        end
        req0 = 4'b0000;
        tick();
        check("nohold_rel", {to0, v0, id0, gnt0}, expv(0, 0, 0));

        // random traffic against the reference model
        @(negedge clk);
        reset_n = 1'b0;
        req8 = '0;
        req4 = '0;
        req0 = '0;
        m8 = mreset();
        m4 = mreset();
        m0 = mreset();
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req8 = req8 ^ (4'($urandom) & 4'($urandom));
            req4 = req4 ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            req0 = req0 ^ (4'($urandom) & 4'($urandom));
            m8 = mstep(m8, req8, 8);
            m4 = mstep(m4, req4, 4);
            m0 = mstep(m0, req0, 0);
            tick();
            check($sformatf("rnd8_%0d", i), {to8, v8, id8, gnt8}, mexp(m8));
            check($sformatf("rnd4_%0d", i), {to4, v4, id4, gnt4}, mexp(m4));
            check($sformatf("rnd0_%0d", i), {to0, v0, id0, gnt0}, mexp(m0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one resource, such as a register-file write port or memory bus, among four masters.
- Encodes the winner as a 2-bit ID plus valid, then decodes it to a one-hot grant vector (2:4 decode enabled by valid).
- Holds the grant until the owner drops its request or a hold-timeout expires.
- Sits between the requesting units and the shared resource's select/enable logic.

Parameters:
- MAX_HOLD, default 8: maximum consecutive BUSY cycles per grant. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; req[i] high means requester i wants the resource.
- gnt  output  4  one-hot grant; all zero when gnt_valid=0.
- gnt_id  output  2  binary index of the current owner.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (reset_n=0, asynchronous, effective immediately, including mid-grant):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0.
- Registered state: state {IDLE, BUSY}, ptr[1:0] (highest-priority index), hold_cnt[7:0], gnt_id, gnt_valid, timeout.
- gnt is purely combinational from registered values: gnt[k] = gnt_valid & (gnt_id==k). Exactly one bit is high when valid; no glitch path from req to gnt.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the next edge: gnt_id=winner, gnt_valid=1, hold_cnt=0, state->BUSY.
  - Latency is 1 cycle from req sampled high to gnt visible.
- BUSY, normal release:
  - Release condition: req[gnt_id]==0 sampled.
  - At the next edge: gnt_valid=0, ptr=gnt_id+1 (mod 4, so 3 wraps to 0), state->IDLE, hold_cnt=0.
- BUSY, timeout release:
  - Applies when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with req[gnt_id] still high.
  - Release happens exactly as for a normal release, and timeout=1 for that one following cycle.
- BUSY, otherwise: hold_cnt increments by 1 per cycle (saturates at 255 when MAX_HOLD=0).
- A grant therefore lasts at most MAX_HOLD cycles of gnt_valid=1.
- Non-owner requests are ignored while BUSY and never preempt the owner.
- After every release there is at least one IDLE cycle with gnt_valid=0 (bus turnaround). The next grant appears on the following edge if any req is pending.
- A requester that timed out and keeps req high re-competes normally. Because ptr has moved past it, it has lowest priority in the next round.
- timeout is 0 in all cycles other than the single post-revocation cycle.
- If release and a new req from the owner coincide, release wins. The owner is re-granted only through normal IDLE arbitration.
- gnt_id holds its last value while gnt_valid=0. Consumers must qualify it with gnt_valid.

Test Plan:
- Reset state:
  - Drive reset_n=0, with req=4'b1111 held throughout reset.
  - During reset, gnt=0, gnt_valid=0 and timeout=0.
  - After release, the first edge grants ID 0 (gnt=4'b0001).
- Round-robin rotation (MAX_HOLD=8):
  - Hold req=4'b1111; each owner drops its req 2 cycles after grant, then reasserts it.
  - Grant order is 0,1,2,3,0 with one gnt_valid=0 cycle between grants.
- Pointer skip and wrap:
  - After the owner-3 release (ptr=0), drive req=4'b0100; grant goes to ID 2.
  - After that release (ptr=3), drive req=4'b0011; grant goes to ID 0, confirming wrap-around.
- Timeout (MAX_HOLD=4):
  - Requester 1 holds req high continuously; requester 2 is also pending.
  - gnt_valid is high for exactly 4 cycles, then timeout=1 for one cycle.
  - The next grant goes to ID 2, not 1.
- No preemption:
  - While ID 3 is owner, assert req[0].
  - gnt stays 4'b1000 until req[3] falls; ID 0 is granted 2 edges later.
- Async reset mid-grant:
  - Pulse reset_n low between clock edges while BUSY.
  - gnt drops to 0 before the next edge; ptr=0 afterwards.
- MAX_HOLD=0:
  - A single requester holds req for 300 cycles.
  - The grant persists for all 300 cycles and timeout never asserts.
